// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the serial line, the frame configuration and the received-byte
// outputs of the UART receiver.
//   master: line/config driver (transmitter side or bench); observes received data
//   slave : the receiver; samples line/config, drives data_out, rx_active, rx_done,
//           parity_error, frame_error
interface uart_rx_if;
    logic       rx;            // serial line, idle high
    logic [1:0] baud_rate;     // 00=4800 01=9600 10=19200 11=38400
    logic [1:0] parity_type;   // 00/11=none 01=odd 10=even
    logic       stop_bits;     // 0=one, 1=two
    logic       data_length;   // 0=7 bits, 1=8 bits
    logic [7:0] data_out;
    logic       rx_active;
    logic       rx_done;
    logic       parity_error;
    logic       frame_error;

    modport master (
        output rx, baud_rate, parity_type, stop_bits, data_length,
        input  data_out, rx_active, rx_done, parity_error, frame_error
    );

    modport slave (
        input  rx, baud_rate, parity_type, stop_bits, data_length,
        output data_out, rx_active, rx_done, parity_error, frame_error
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, LSB first, 7/8 data bits, optional odd/even
// parity, 1/2 stop bits, four selectable baud rates.
// Ports:
//   clk    : system clock, rising edge
//   arst_n : asynchronous active-low reset
//   bus    : uart_rx_if.slave (rx line, frame config in; data_out, rx_active, rx_done,
//            parity_error, frame_error out)
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input logic      clk,
    input logic      arst_n,
    uart_rx_if.slave bus
);
    localparam int unsigned Div4800  = CLK_FREQ / (16 * 4800);
    localparam int unsigned Div9600  = CLK_FREQ / (16 * 9600);
    localparam int unsigned Div19200 = CLK_FREQ / (16 * 19200);
    localparam int unsigned Div38400 = CLK_FREQ / (16 * 38400);
    localparam int unsigned CntW     = (Div4800 > 1) ? $clog2(Div4800) : 1;

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StDone, StBreak
    } state_e;

    state_e          r_state;
    logic            r_sync1, r_sync2;
    logic [CntW-1:0] r_div_cnt;
    logic [3:0]      r_tick_cnt;
    logic [2:0]      r_bit_cnt;
    logic            r_stop_cnt;
    logic [7:0]      r_shift;
    logic [1:0]      r_baud;
    logic [1:0]      r_parity;
    logic            r_stop2;
    logic            r_len8;
    logic            r_perr;
    logic            r_ferr;
    logic [7:0]      r_data_out;
    logic            r_rx_active;
    logic            r_rx_done;
    logic            r_parity_error;
    logic            r_frame_error;

    logic            w_rxs;
    logic [CntW-1:0] w_div_max;
    logic            w_tick;
    logic            w_sample;
    logic [7:0]      w_data;
    logic            w_par_en;
    logic [2:0]      w_last_bit;

    assign w_rxs = r_sync2;

    always_comb begin
        w_div_max = '0;
        case (r_baud)
            2'b00:   w_div_max = CntW'(Div4800 - 1);
            2'b01:   w_div_max = CntW'(Div9600 - 1);
            2'b10:   w_div_max = CntW'(Div19200 - 1);
            default: w_div_max = CntW'(Div38400 - 1);
        endcase
    end

    assign w_tick     = (r_div_cnt == w_div_max);
    // One sample per bit: every 16th tick after the mid-start realignment.
    assign w_sample   = w_tick && (r_tick_cnt == 4'd15);
    // In 7-bit mode only seven shifts happen, so the byte sits in [7:1].
    assign w_data     = r_len8 ? r_shift : {1'b0, r_shift[7:1]};
    assign w_par_en   = r_parity[0] ^ r_parity[1];
    assign w_last_bit = r_len8 ? 3'd7 : 3'd6;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state        <= StIdle;
            r_sync1        <= 1'b1;
            r_sync2        <= 1'b1;
            r_div_cnt      <= '0;
            r_tick_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_stop_cnt     <= 1'b0;
            r_shift        <= '0;
            r_baud         <= '0;
            r_parity       <= '0;
            r_stop2        <= 1'b0;
            r_len8         <= 1'b0;
            r_perr         <= 1'b0;
            r_ferr         <= 1'b0;
            r_data_out     <= '0;
            r_rx_active    <= 1'b0;
            r_rx_done      <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_sync1   <= bus.rx;
            r_sync2   <= r_sync1;
            r_rx_done <= 1'b0;

            // Divider is parked at zero in IDLE so ticks align to the start edge.
            if (r_state == StIdle || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end

            unique case (r_state)
                StIdle: begin
                    if (!w_rxs) begin
                        r_state     <= StStart;
                        r_rx_active <= 1'b1;
                        r_baud      <= bus.baud_rate;
                        r_parity    <= bus.parity_type;
                        r_stop2     <= bus.stop_bits;
                        r_len8      <= bus.data_length;
                        r_tick_cnt  <= '0;
                        r_bit_cnt   <= '0;
                        r_stop_cnt  <= 1'b0;
                        r_perr      <= 1'b0;
                        r_ferr      <= 1'b0;
                    end
                end
                StStart: begin
                    if (w_tick && r_tick_cnt == 4'd7) begin
                        r_tick_cnt <= '0;
                        if (w_rxs) begin
                            r_state     <= StIdle;
                            r_rx_active <= 1'b0;
                        end else begin
                            r_state <= StData;
                        end
                    end
                end
                StData: begin
                    if (w_sample) begin
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == w_last_bit) begin
                            r_state <= w_par_en ? StParity : StStop;
                        end
                    end
                end
                StParity: begin
                    if (w_sample) begin
                        r_perr  <= (r_parity == 2'b01) ? ~(^{w_data, w_rxs}) : (^{w_data, w_rxs});
                        r_state <= StStop;
                    end
                end
                StStop: begin
                    if (w_sample) begin
                        if (r_stop_cnt == r_stop2) begin
                            r_data_out     <= w_data;
                            r_parity_error <= r_perr;
                            r_frame_error  <= r_ferr | ~w_rxs;
                            r_rx_done      <= 1'b1;
                            r_rx_active    <= 1'b0;
                            r_state        <= w_rxs ? StDone : StBreak;
                        end else begin
                            r_stop_cnt <= 1'b1;
                            r_ferr     <= r_ferr | ~w_rxs;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                StBreak: begin
                    // Wait for the line to recover so a held-low line cannot re-trigger.
                    if (w_rxs) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.rx_active    = r_rx_active;
    assign bus.rx_done      = r_rx_done;
    assign bus.parity_error = r_parity_error;
    assign bus.frame_error  = r_frame_error;
endmodule
